wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 138 +++++++++++++
 tb/tb_wb_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: holds one committed instruction and fans it out to the regfile, CSR file and trace port.
// Exceptions and ertn raise csr_reset so that upstream stages flush and this stage empties on the next edge.
module wb_stage #(
  parameter int CSR_NUM_WIDTH = 14,
  parameter int TO_WB_WIDTH   = 116 + CSR_NUM_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [TO_WB_WIDTH-1:0]   to_WB_data,
  input  logic                     MEM_to_WB_valid,
  output logic                     WB_allow_in,
  input  logic [31:0]              csr_rvalue,
  input  logic [31:0]              csr_tid,
  output logic [CSR_NUM_WIDTH-1:0] csr_num_o,
  output logic                     csr_we,
  output logic [31:0]              csr_wvalue,
  output logic [31:0]              csr_wmask,
  output logic                     wb_ex,
  output logic [5:0]               wb_ecode,
  output logic [8:0]               wb_esubcode,
  output logic [31:0]              wb_pc,
  output logic [31:0]              wb_badv,
  output logic                     ertn_flush,
  output logic                     csr_reset,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  output logic [37:0]              WB_forward,
  output logic [31:0]              debug_wb_pc,
  output logic [3:0]               debug_wb_rf_we,
  output logic [4:0]               debug_wb_rf_wnum,
  output logic [31:0]              debug_wb_rf_wdata
);

  logic                     wb_valid;
  logic [TO_WB_WIDTH-1:0]   payload;
  logic                     ready_go;
  logic                     live;
  logic                     has_ex;

  logic [31:0]              pc;
  logic [4:0]               dest;
  logic [31:0]              result;
  logic                     gr_we;
  logic                     ex_int;
  logic                     ex_sys;
  logic                     ex_brk;
  logic                     ex_adef;
  logic                     ex_adem;
  logic                     ex_ine;
  logic                     is_ertn;
  logic                     op_csr;
  logic [CSR_NUM_WIDTH-1:0] csr_num;
  logic [31:0]              wmask_field;
  logic [4:0]               rj;
  logic                     rdcntid;

  assign ready_go    = 1'b1;
  assign WB_allow_in = ~wb_valid | ready_go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid <= 1'b0;
    end else if (csr_reset) begin
      // the committing instruction flushes everything behind it, including what MEM offers now
      wb_valid <= 1'b0;
    end else if (WB_allow_in) begin
      wb_valid <= MEM_to_WB_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (WB_allow_in && MEM_to_WB_valid) begin
      payload <= to_WB_data;
    end
  end

  assign {pc, dest, result, gr_we, ex_int, ex_sys, ex_brk, ex_adef, ex_adem, ex_ine,
          is_ertn, op_csr, csr_num, wmask_field, rj, rdcntid} = payload;

  // reset in the middle of a commit kills its strobes without waiting for the flop to settle
  assign live   = wb_valid & ~reset;
  assign has_ex = live & (ex_int | ex_adef | ex_ine | ex_sys | ex_brk | ex_adem);

  always_comb begin
    wb_ecode    = 6'h00;
    wb_esubcode = 9'h000;
    wb_badv     = 32'h0;
    if (has_ex) begin
      if (ex_int) begin
        wb_ecode = 6'h00;
      end else if (ex_adef) begin
        wb_ecode = 6'h08;
        wb_badv  = pc;
      end else if (ex_ine) begin
        wb_ecode = 6'h0D;
      end else if (ex_sys) begin
        wb_ecode = 6'h0B;
      end else if (ex_brk) begin
        wb_ecode = 6'h0C;
      end else begin
        wb_ecode    = 6'h08;
        wb_esubcode = 9'h001;
        wb_badv     = result;
      end
    end
  end

  assign wb_ex      = has_ex;
  assign wb_pc      = pc;
  assign ertn_flush = live & is_ertn & ~has_ex;
  assign csr_reset  = wb_ex | ertn_flush;

  assign csr_num_o  = csr_num;
  assign csr_we     = live & op_csr & (rj != 5'd0) & ~has_ex;
  assign csr_wvalue = result;
  assign csr_wmask  = (rj == 5'd1) ? 32'hFFFF_FFFF : wmask_field;

  assign rf_we    = live & gr_we & ~has_ex;
  assign rf_waddr = dest;

  always_comb begin
    rf_wdata = result;
    if (rdcntid) begin
      rf_wdata = csr_tid;
    end else if (op_csr) begin
      rf_wdata = csr_rvalue;
    end
  end

  assign WB_forward = {dest & {5{live}}, rf_wdata, op_csr & live};

  assign debug_wb_pc       = wb_pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed instructions push hand-computed commits,
// a negedge monitor pops and compares whenever the stage shows a side effect.
module tb_wb_stage;

  localparam int CW = 14;
  localparam int W  = 116 + CW;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  to_WB_data;
  logic          MEM_to_WB_valid;
  logic          WB_allow_in;
  logic [31:0]   csr_rvalue;
  logic [31:0]   csr_tid;
  logic [CW-1:0] csr_num_o;
  logic          csr_we;
  logic [31:0]   csr_wvalue;
  logic [31:0]   csr_wmask;
  logic          wb_ex;
  logic [5:0]    wb_ecode;
  logic [8:0]    wb_esubcode;
  logic [31:0]   wb_pc;
  logic [31:0]   wb_badv;
  logic          ertn_flush;
  logic          csr_reset;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic [37:0]   WB_forward;
  logic [31:0]   debug_wb_pc;
  logic [3:0]    debug_wb_rf_we;
  logic [4:0]    debug_wb_rf_wnum;
  logic [31:0]   debug_wb_rf_wdata;

  wb_stage #(.CSR_NUM_WIDTH(CW), .TO_WB_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .to_WB_data(to_WB_data), .MEM_to_WB_valid(MEM_to_WB_valid),
    .WB_allow_in(WB_allow_in), .csr_rvalue(csr_rvalue), .csr_tid(csr_tid),
    .csr_num_o(csr_num_o), .csr_we(csr_we), .csr_wvalue(csr_wvalue), .csr_wmask(csr_wmask),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
    .wb_badv(wb_badv), .ertn_flush(ertn_flush), .csr_reset(csr_reset), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .WB_forward(WB_forward),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   pc;
    logic [4:0]    dest;
    logic [31:0]   result;
    logic          gr_we, ex_int, ex_sys, ex_brk, ex_adef, ex_adem, ex_ine, ertn, op_csr;
    logic [CW-1:0] cnum;
    logic [31:0]   wmask;
    logic [4:0]    rj;
    logic          rdcntid;
  } in_t;

  typedef struct {
    logic          rf_we;
    logic [4:0]    waddr;
    logic [31:0]   wdata;
    logic          csr_we;
    logic [CW-1:0] cnum;
    logic [31:0]   cwval;
    logic [31:0]   cwmask;
    logic          ex;
    logic [5:0]    ecode;
    logic [8:0]    esub;
    logic [31:0]   badv;
    logic [31:0]   pc;
    logic          ertn;
    logic          op_csr;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input in_t v);
    return {v.pc, v.dest, v.result, v.gr_we, v.ex_int, v.ex_sys, v.ex_brk, v.ex_adef,
            v.ex_adem, v.ex_ine, v.ertn, v.op_csr, v.cnum, v.wmask, v.rj, v.rdcntid};
  endfunction

  function automatic in_t blank_in();
    in_t r;
    r = '{default: '0};
    return r;
  endfunction

  function automatic exp_t blank_exp();
    exp_t r;
    r = '{default: '0};
    return r;
  endfunction

  // monitor: any visible side effect must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (rf_we || csr_we || wb_ex || ertn_flush)) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_commit: got pc 0x%0h rf_we %0b wb_ex %0b, expected no commit",
                 wb_pc, rf_we, wb_ex);
      end else begin
        e = q.pop_front();
        chk("rf_we", rf_we, e.rf_we);
        chk("wb_ex", wb_ex, e.ex);
        chk("ertn_flush", ertn_flush, e.ertn);
        chk("csr_we", csr_we, e.csr_we);
        chk("csr_reset", csr_reset, e.ex | e.ertn);
        chk("wb_pc", wb_pc, e.pc);
        chk("debug_wb_pc", debug_wb_pc, e.pc);
        chk("debug_wb_rf_we", debug_wb_rf_we, {4{e.rf_we}});
        if (e.rf_we) begin
          chk("rf_waddr", rf_waddr, e.waddr);
          chk("rf_wdata", rf_wdata, e.wdata);
          chk("debug_wb_rf_wnum", debug_wb_rf_wnum, e.waddr);
          chk("debug_wb_rf_wdata", debug_wb_rf_wdata, e.wdata);
          chk("WB_forward", WB_forward, {e.waddr, e.wdata, e.op_csr});
        end
        if (e.csr_we) begin
          chk("csr_num_o", csr_num_o, e.cnum);
          chk("csr_wvalue", csr_wvalue, e.cwval);
          chk("csr_wmask", csr_wmask, e.cwmask);
        end
        if (e.ex) begin
          chk("wb_ecode", wb_ecode, e.ecode);
          chk("wb_esubcode", wb_esubcode, e.esub);
          chk("wb_badv", wb_badv, e.badv);
        end
      end
    end
  end

  // one instruction offered for one cycle; optionally MEM offers another right behind it
  task automatic issue(input in_t v, input logic [31:0] rval, input logic [31:0] tid,
                       input exp_t e, input bit follow, input in_t fv);
    @(posedge clk); #1;
    to_WB_data      = pack(v);
    MEM_to_WB_valid = 1'b1;
    csr_rvalue      = rval;
    csr_tid         = tid;
    q.push_back(e);
    @(posedge clk); #1;
    if (follow) begin
      to_WB_data = pack(fv);
      @(posedge clk); #1;
    end
    MEM_to_WB_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "timeout");
  end

  initial begin
    in_t  v, nv;
    exp_t e;
    reset           = 1'b1;
    to_WB_data      = '0;
    MEM_to_WB_valid = 1'b0;
    csr_rvalue      = 32'h0;
    csr_tid         = 32'hDEAD_0000;
    nv              = blank_in();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_csr_reset", csr_reset, 1'b0);
    chk("rst_wb_ex", wb_ex, 1'b0);
    chk("allow_in", WB_allow_in, 1'b1);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    chk("post_rst_strobes", {rf_we, csr_we, wb_ex, ertn_flush, csr_reset}, 5'b0);

    // plain load
    v = blank_in(); v.pc = 32'h1C00_0010; v.dest = 5'd4; v.gr_we = 1'b1; v.result = 32'hDEAD_BEEF;
    e = blank_exp(); e.pc = v.pc; e.rf_we = 1'b1; e.waddr = 5'd4; e.wdata = 32'hDEAD_BEEF;
    issue(v, 32'h0, 32'hDEAD_0000, e, 1'b0, nv);

    // csrxchg: masked write, rd gets old CSR value
    v = blank_in(); v.pc = 32'h1C00_0014; v.op_csr = 1'b1; v.rj = 5'd7; v.wmask = 32'hFF;
    v.result = 32'h12; v.cnum = 14'h005; v.gr_we = 1'b1; v.dest = 5'd6;
    e = blank_exp(); e.pc = v.pc; e.csr_we = 1'b1; e.cnum = 14'h005; e.cwval = 32'h12;
    e.cwmask = 32'hFF; e.rf_we = 1'b1; e.waddr = 5'd6; e.wdata = 32'hAB; e.op_csr = 1'b1;
    issue(v, 32'hAB, 32'hDEAD_0000, e, 1'b0, nv);

    // csrwr (rj == 1) writes every bit regardless of the mask field
    v = blank_in(); v.pc = 32'h1C00_0018; v.op_csr = 1'b1; v.rj = 5'd1; v.wmask = 32'h0F;
    v.result = 32'h55; v.cnum = 14'h006; v.gr_we = 1'b1; v.dest = 5'd7;
    e = blank_exp(); e.pc = v.pc; e.csr_we = 1'b1; e.cnum = 14'h006; e.cwval = 32'h55;
    e.cwmask = 32'hFFFF_FFFF; e.rf_we = 1'b1; e.waddr = 5'd7; e.wdata = 32'h77; e.op_csr = 1'b1;
    issue(v, 32'h77, 32'hDEAD_0000, e, 1'b0, nv);

    // csrrd (rj == 0) reads only
    v = blank_in(); v.pc = 32'h1C00_001C; v.op_csr = 1'b1; v.rj = 5'd0; v.result = 32'h66;
    v.cnum = 14'h007; v.gr_we = 1'b1; v.dest = 5'd8;
    e = blank_exp(); e.pc = v.pc; e.rf_we = 1'b1; e.waddr = 5'd8; e.wdata = 32'h99; e.op_csr = 1'b1;
    issue(v, 32'h99, 32'hDEAD_0000, e, 1'b0, nv);

    // ADEM + SYS: SYS wins; the instruction MEM offers in the commit cycle must be dropped
    v = blank_in(); v.pc = 32'h1C00_0020; v.ex_adem = 1'b1; v.ex_sys = 1'b1; v.result = 32'h1001;
    v.gr_we = 1'b1; v.dest = 5'd9;
    e = blank_exp(); e.pc = v.pc; e.ex = 1'b1; e.ecode = 6'h0B; e.esub = 9'h0; e.badv = 32'h0;
    nv = blank_in(); nv.pc = 32'h1C00_0024; nv.gr_we = 1'b1; nv.dest = 5'd10; nv.result = 32'h1234;
    issue(v, 32'h0, 32'hDEAD_0000, e, 1'b1, nv);
    nv = blank_in();

    // ADEM alone
    v = blank_in(); v.pc = 32'h1C00_0030; v.ex_adem = 1'b1; v.result = 32'h1002;
    e = blank_exp(); e.pc = v.pc; e.ex = 1'b1; e.ecode = 6'h08; e.esub = 9'h1; e.badv = 32'h1002;
    issue(v, 32'h0, 32'hDEAD_0000, e, 1'b0, nv);

    // ADEF beats INE and ADEM; badv is the pc
    v = blank_in(); v.pc = 32'h1C00_0041; v.ex_adef = 1'b1; v.ex_ine = 1'b1; v.ex_adem = 1'b1;
    v.result = 32'h5555;
    e = blank_exp(); e.pc = v.pc; e.ex = 1'b1; e.ecode = 6'h08; e.esub = 9'h0; e.badv = 32'h1C00_0041;
    issue(v, 32'h0, 32'hDEAD_0000, e, 1'b0, nv);

    // INT over everything, and it suppresses csr write, rf write and ertn
    v = blank_in(); v.pc = 32'h1C00_0044; v.ex_int = 1'b1; v.ex_adef = 1'b1; v.op_csr = 1'b1;
    v.rj = 5'd3; v.gr_we = 1'b1; v.dest = 5'd11; v.ertn = 1'b1;
    e = blank_exp(); e.pc = v.pc; e.ex = 1'b1; e.ecode = 6'h00; e.esub = 9'h0; e.badv = 32'h0;
    issue(v, 32'h0, 32'hDEAD_0000, e, 1'b0, nv);

    // INE over SYS
    v = blank_in(); v.pc = 32'h1C00_0048; v.ex_ine = 1'b1; v.ex_sys = 1'b1; v.ex_brk = 1'b1;
    e = blank_exp(); e.pc = v.pc; e.ex = 1'b1; e.ecode = 6'h0D;
    issue(v, 32'h0, 32'hDEAD_0000, e, 1'b0, nv);

    // BRK over ADEM
    v = blank_in(); v.pc = 32'h1C00_004C; v.ex_brk = 1'b1; v.ex_adem = 1'b1; v.result = 32'h77;
    e = blank_exp(); e.pc = v.pc; e.ex = 1'b1; e.ecode = 6'h0C;
    issue(v, 32'h0, 32'hDEAD_0000, e, 1'b0, nv);

    // ertn
    v = blank_in(); v.pc = 32'h1C00_0050; v.ertn = 1'b1;
    e = blank_exp(); e.pc = v.pc; e.ertn = 1'b1;
    issue(v, 32'h0, 32'hDEAD_0000, e, 1'b0, nv);

    // rdcntid takes the TID, not the CSR read data or the result
    v = blank_in(); v.pc = 32'h1C00_0054; v.rdcntid = 1'b1; v.gr_we = 1'b1; v.dest = 5'd5;
    v.result = 32'h4444;
    e = blank_exp(); e.pc = v.pc; e.rf_we = 1'b1; e.waddr = 5'd5; e.wdata = 32'h3;
    issue(v, 32'hABCD, 32'h3, e, 1'b0, nv);

    // reset during an exception commit cancels it at once
    repeat (2) @(posedge clk);
    #1;
    v = blank_in(); v.pc = 32'h1C00_0060; v.ex_sys = 1'b1; v.gr_we = 1'b1; v.dest = 5'd12;
    to_WB_data      = pack(v);
    MEM_to_WB_valid = 1'b1;
    @(posedge clk); #1;
    MEM_to_WB_valid = 1'b0;
    chk("pre_reset_wb_ex", wb_ex, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_wb_ex", wb_ex, 1'b0);
    chk("mid_reset_csr_reset", csr_reset, 1'b0);
    chk("mid_reset_rf_we", rf_we, 1'b0);
    @(posedge clk); #1;
    chk("hold_reset_strobes", {rf_we, csr_we, wb_ex, ertn_flush, csr_reset}, 5'b0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    chk("after_reset_strobes", {rf_we, csr_we, wb_ex, ertn_flush, csr_reset}, 5'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
